// File: rtl/nco_sweep_pkg.sv
// Shared types and default widths for the NCO sweep controller and the NCO wrapper.
// Optional feature: NCO_SWEEP_BIDIR_EN adds the DOWN state (triangular sweep).
package nco_sweep_pkg;

  localparam int APR_DEF     = 20;
  localparam int DWELL_W_DEF = 16;

`ifdef NCO_SWEEP_BIDIR_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UP     = 2'd1,
    ST_DOWN   = 2'd2,
    ST_FINISH = 2'd3
  } sweep_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UP     = 2'd1,
    ST_FINISH = 2'd3
  } sweep_state_t;
`endif

endpackage

// File: rtl/nco_sweep_dwell.sv
// Loadable dwell down-counter: tick is high for one enabled cycle when the count is 0,
// and the count reloads on tick (from reload_val) or on load (from load_val).
module nco_sweep_dwell #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clken,
  input  logic         active,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] reload_val,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = clken && active && !load && (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clken) begin
      if (load) begin
        cnt <= load_val;
      end else if (active) begin
        cnt <= (cnt == '0) ? reload_val : cnt - W'(1);
      end
    end
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped linear chirp generator feeding the NCO phase increment; each value held dwell+1 enabled cycles.
// Optional feature: NCO_SWEEP_BIDIR_EN enables triangular (up/down) sweeps; otherwise sawtooth only.
module nco_sweep_ctrl
  import nco_sweep_pkg::*;
#(
  parameter int APR     = APR_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clken,
  input  logic               start,
  input  logic               abort,
  input  logic               continuous,
  input  logic [APR-1:0]     inc_start,
  input  logic [APR-1:0]     inc_stop,
  input  logic [APR-1:0]     inc_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [APR-1:0]     phi_inc_o,
  output logic               busy,
  output logic               done,
  output logic               dir_down
);

  sweep_state_t       state;
  logic [APR-1:0]     cfg_start;
  logic [APR-1:0]     cfg_stop;
  logic [APR-1:0]     cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_cont;

  logic               tick;
  logic               start_acc;
  logic               degen;
  logic               at_top;
  logic [APR:0]       sum;
  logic [APR-1:0]     up_next;

  assign start_acc = (state == ST_IDLE) && start && !abort;

  // A zero step or an empty range never advances: hold inc_start, then end the ramp.
  assign degen   = (cfg_step == '0) || (cfg_stop <= cfg_start);
  assign sum     = {1'b0, phi_inc_o} + {1'b0, cfg_step};
  assign up_next = degen ? cfg_start :
                   (sum >= {1'b0, cfg_stop}) ? cfg_stop : sum[APR-1:0];
  assign at_top  = degen || (phi_inc_o >= cfg_stop);

`ifdef NCO_SWEEP_BIDIR_EN
  logic [APR:0]   diff;
  logic [APR-1:0] down_next;
  logic           at_bot;
  logic           dir_q;

  assign diff      = {1'b0, phi_inc_o} - {1'b0, cfg_step};
  assign down_next = (diff[APR] || (diff[APR-1:0] <= cfg_start)) ? cfg_start : diff[APR-1:0];
  assign at_bot    = (phi_inc_o <= cfg_start);
  assign dir_down  = dir_q;
`else
  assign dir_down  = 1'b0;
`endif

  nco_sweep_dwell #(
    .W (DWELL_W)
  ) u_dwell (
    .clk        (clk),
    .reset      (reset),
    .clken      (clken),
    .active     (state != ST_IDLE),
    .load       (start_acc),
    .load_val   (dwell),
    .reload_val (cfg_dwell),
    .tick       (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      phi_inc_o <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_start <= '0;
      cfg_stop  <= '0;
      cfg_step  <= '0;
      cfg_dwell <= '0;
      cfg_cont  <= 1'b0;
`ifdef NCO_SWEEP_BIDIR_EN
      dir_q     <= 1'b0;
`endif
    end else if (clken) begin
      done <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
`ifdef NCO_SWEEP_BIDIR_EN
        dir_q <= 1'b0;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              cfg_start <= inc_start;
              cfg_stop  <= inc_stop;
              cfg_step  <= inc_step;
              cfg_dwell <= dwell;
              cfg_cont  <= continuous;
              phi_inc_o <= inc_start;
              busy      <= 1'b1;
              state     <= ST_UP;
            end
          end
          ST_UP: begin
            if (tick) begin
              if (!at_top) begin
                phi_inc_o <= up_next;
`ifdef NCO_SWEEP_BIDIR_EN
              end else begin
                state     <= ST_DOWN;
                dir_q     <= 1'b1;
                phi_inc_o <= down_next;
              end
`else
              end else if (cfg_cont) begin
                phi_inc_o <= cfg_start;
              end else begin
                state <= ST_FINISH;
              end
`endif
            end
          end
`ifdef NCO_SWEEP_BIDIR_EN
          ST_DOWN: begin
            if (tick) begin
              if (!at_bot) begin
                phi_inc_o <= down_next;
              end else if (cfg_cont) begin
                state     <= ST_UP;
                dir_q     <= 1'b0;
                phi_inc_o <= up_next;
              end else begin
                state <= ST_FINISH;
                dir_q <= 1'b0;
              end
            end
          end
`endif
          ST_FINISH: begin
            if (tick) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Frequency-sweep controller sitting directly upstream of the NCO. It drives the NCO phase-increment input (`phi_inc_i`, APR bits) with a stepped linear chirp from a start increment to a stop increment. Each increment value is held for a programmable dwell, with optional repeat and optional up/down (triangular) sweeping. The output is a registered increment word; the NCO consumes it unchanged on the same clock and `clken`.

## Interface

Parameters:
- `APR`, 20: phase-increment width; must match the NCO accumulator width.
- `DWELL_W`, 16: dwell counter width.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `clken`, in, 1: global enable; when low all state, counters and outputs freeze.
- `start`, in, 1: sampled when `clken`=1 and the FSM is in IDLE; launches a sweep.
- `abort`, in, 1: terminates any sweep; priority over everything except reset.
- `continuous`, in, 1: latched at start; 1 = repeat the sweep indefinitely.
- `inc_start`, in, APR: first increment (unsigned).
- `inc_stop`, in, APR: terminal increment (unsigned).
- `inc_step`, in, APR: per-step delta (unsigned).
- `dwell`, in, DWELL_W: each value is held for dwell+1 enabled cycles.
- `phi_inc_o`, out, APR: drives NCO `phi_inc_i`.
- `busy`, out, 1: sweep in progress.
- `done`, out, 1: one-cycle pulse at normal sweep completion.
- `dir_down`, out, 1: 1 while descending; constant 0 when the BIDIR feature is excluded.

## Operation

- Reset values:
  - `phi_inc_o`=0, `busy`=0, `done`=0, `dir_down`=0.
  - State IDLE; dwell counter 0.
- States: IDLE, UP, DOWN (DOWN exists only when the BIDIR feature is compiled in), FINISH.
- Every transition and counter update is qualified by `clken`=1.
- IDLE + `start`:
  - Latch `inc_start`, `inc_stop`, `inc_step`, `dwell` and `continuous`. Later changes to these inputs have no effect mid-sweep.
  - Load `phi_inc_o`=`inc_start`, load the dwell counter with `dwell`, go to UP.
- Dwell:
  - The counter decrements each enabled cycle.
  - At 0 it reloads `dwell` and a step event occurs.
- UP step event:
  - Form `sum = phi_inc_o + inc_step` at APR+1 bits.
  - If `sum >= inc_stop`, load `inc_stop` and take the end-of-up action.
  - Otherwise load `sum`.
  - The carry bit is included in the comparison, so there is no wrap-around.
- End-of-up action, BIDIR excluded:
  - `continuous`=1: load `inc_start` and stay in UP.
  - `continuous`=0: go to FINISH.
- Degenerate configuration: `inc_step`=0 or `inc_stop <= inc_start`.
  - `phi_inc_o` stays at `inc_start` for one dwell period.
  - Then the end-of-up action is taken, but the next value is always `inc_start`.
- FINISH: hold `phi_inc_o` for one dwell period, then go to IDLE.
- `start` while busy is ignored.
- `abort`:
  - Next enabled cycle: IDLE, `busy`=0, no `done` pulse.
  - `phi_inc_o` keeps its current value.
- `start` and `abort` in the same cycle: abort wins and `start` is dropped.
- `phi_inc_o` holds its last value in IDLE, so the NCO keeps running at the final frequency.

## Timing

- `start` sampled at edge N → at edge N+1: `busy`=1 and `phi_inc_o`=`inc_start`.
- Every value is present for exactly dwell+1 enabled cycles, the terminal value included.
- `phi_inc_o` updates on the edge after the dwell counter reads 0.
- `done` is high for the single cycle in which `busy` first reads 0 after FINISH.
- A `start` in that same `done` cycle is accepted, giving back-to-back sweeps.
- `reset` asserted mid-sweep forces the reset values immediately, independent of `clk`.

## Configuration

- Macro `NCO_SWEEP_BIDIR_EN`.
- Defined, end-of-up action:
  - Go to DOWN with `dir_down`=1.
  - Each DOWN step loads `diff = phi_inc_o - inc_step`, clamped to `inc_start` when the result would be `<= inc_start` (including borrow).
- Defined, on reaching `inc_start` in DOWN:
  - `continuous`=1: go to UP with `dir_down`=0.
  - `continuous`=0: go to FINISH.
- Undefined:
  - DOWN state and subtract path are absent.
  - `dir_down` is tied to 0; the sweep is sawtooth only.

## Structure

- Package `nco_sweep_pkg`:
  - State enum `sweep_state_t`.
  - Default `APR`=20 and `DWELL_W`=16 constants, shared with the NCO wrapper.
- Sub-module `nco_sweep_dwell`:
  - Loadable down-counter with `clken`.
  - Outputs a one-cycle `tick` when the count is 0; reloads on `tick` or `load`.

## Test plan

- Reset mid-sweep:
  - Stimulus: `inc_start`=100, `inc_stop`=400, `inc_step`=100, `dwell`=0, `continuous`=0, pulse `start`.
  - Required: `phi_inc_o` reads 100, 200, 300, 400, 400 on consecutive cycles; `done` pulses one cycle later.
  - Asserting `reset` at the 200 value → all outputs 0 at once.
- Overshoot clamp:
  - Stimulus: `inc_start`=0, `inc_stop`=250, `inc_step`=100, `dwell`=2.
  - Required: values 0, 100, 200, 250, 250, each held 3 cycles; no overflow past 250.
- Carry at full range:
  - Stimulus: `inc_start`=20'hFFF00, `inc_stop`=20'hFFFFF, `inc_step`=20'h80000.
  - Required: the second value is 20'hFFFFF (carry detected); no wrap to a small value.
- `clken` freeze and abort:
  - Stimulus: `clken` low for 5 cycles mid-dwell.
  - Required: `phi_inc_o` and the dwell count are unchanged; the timing resumes exactly where it stopped.
  - `abort` → `busy`=0 next cycle, no `done`, `phi_inc_o` held.
- Continuous, and BIDIR when built:
  - Stimulus: `continuous`=1, range 10 to 30, step 10, `dwell`=0.
  - Required without `NCO_SWEEP_BIDIR_EN`: 10, 20, 30, 10, 20, …
  - Required with `NCO_SWEEP_BIDIR_EN`: 10, 20, 30, 20, 10, 20, …, with `dir_down` high during the descent.
- Degenerate and busy start:
  - `inc_step`=0 with `dwell`=3, `continuous`=0 → `inc_start` held 4 cycles, FINISH 4 cycles, then `done`.
  - `start` pulsed while `busy`=1 → ignored.
